// File: rtl/feeder_pkg.sv
// Shared types and constants for the digest byte feeder.
// Optional feature macro: FEEDER_CHECKSUM_EN (adds the CHK state).
package feeder_pkg;

  localparam int unsigned WORD_W_DEFAULT = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_W_DEFAULT / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
`ifdef FEEDER_CHECKSUM_EN
    ST_SHIFT = 2'd2,
    ST_CHK   = 2'd3
`else
    ST_SHIFT = 2'd2
`endif
  } state_t;

  localparam state_t     RST_STATE = ST_IDLE;
  localparam logic [7:0] RST_BYTE  = 8'h00;
  localparam logic [7:0] RST_CSUM  = 8'h00;

  function automatic int unsigned bytes_per_word(input int unsigned w);
    return w / 8;
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous word FIFO with full/empty/count; pointers wrap modulo DEPTH.
module feeder_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W-1:0]               wr_data,
  input  logic                       push,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array: written on accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/digest_byte_feeder.sv
// Buffers digest words and unpacks them MSB-byte-first onto a byte stream.
// Optional feature macro: FEEDER_CHECKSUM_EN (XOR checksum byte per frame).
module digest_byte_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned WORD_W = BYTES_PER_WORD * 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  output logic              byte_last,
  input  logic              byte_ready,
  output logic              busy
);

  localparam int unsigned BPW = bytes_per_word(WORD_W);
  localparam int unsigned IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned CW  = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            state_nx;
  logic [WORD_W-1:0] sh;
  logic              last_r;
  logic [IW-1:0]     idx;
  logic              idx_last;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [WORD_W:0]   fifo_rd;
  logic              pop;
  logic              push;
`ifdef FEEDER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign word_ready = !fifo_full;
  assign push       = word_valid && !fifo_full;
  assign idx_last   = (idx == IW'(BPW - 1));
  assign busy       = (fifo_count != '0) || (state != ST_IDLE);

  feeder_fifo #(
    .W     (WORD_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data ({word_last, word_in}),
    .push    (push),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Unpacker state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nx;
  end

  // Next state, FIFO pop and byte-side outputs.
  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    byte_out   = RST_BYTE;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        pop      = !fifo_empty;
        state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        byte_valid = 1'b1;
        byte_out   = sh[WORD_W-1 -: 8];
`ifdef FEEDER_CHECKSUM_EN
        if (byte_ready && idx_last) begin
          if (last_r)          state_nx = ST_CHK;
          else if (fifo_empty) state_nx = ST_IDLE;
          else                 state_nx = ST_LOAD;
        end
`else
        byte_last = last_r && idx_last;
        if (byte_ready && idx_last) state_nx = fifo_empty ? ST_IDLE : ST_LOAD;
`endif
      end
`ifdef FEEDER_CHECKSUM_EN
      ST_CHK: begin
        byte_valid = 1'b1;
        byte_last  = 1'b1;
        byte_out   = csum;
        if (byte_ready) state_nx = fifo_empty ? ST_IDLE : ST_LOAD;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // Shift register, frame-last flag and byte index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh     <= '0;
      last_r <= 1'b0;
      idx    <= '0;
    end else if (state == ST_LOAD) begin
      sh     <= fifo_rd[WORD_W-1:0];
      last_r <= fifo_rd[WORD_W];
      idx    <= '0;
    end else if (state == ST_SHIFT && byte_ready) begin
      sh  <= sh << 8;
      idx <= idx + 1'b1;
    end
  end

`ifdef FEEDER_CHECKSUM_EN
  // XOR over transferred data bytes; cleared when the checksum byte leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  csum <= RST_CSUM;
    else if (state == ST_SHIFT && byte_ready) csum <= csum ^ sh[WORD_W-1 -: 8];
    else if (state == ST_CHK && byte_ready)   csum <= RST_CSUM;
  end
`endif

endmodule

// File: tb/tb_digest_byte_feeder.sv
// Directed self-checking bench for digest_byte_feeder.
// Honours FEEDER_CHECKSUM_EN when building expected byte streams.
module tb_digest_byte_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_last = 1'b0;
  logic        word_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [8:0]  exp_q[$];
  logic [32:0] word_q[$];
  logic [7:0]  model_x = 8'h00;

  digest_byte_feeder #(.WORD_W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_last  (word_last),
    .word_ready (word_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=completion", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected byte stream for one word (running XOR per frame).
  task automatic add_exp(input logic [31:0] w, input logic last);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[31-8*i -: 8];
      model_x = model_x ^ b;
`ifdef FEEDER_CHECKSUM_EN
      exp_q.push_back({1'b0, b});
`else
      exp_q.push_back({last && (i == 3), b});
`endif
    end
`ifdef FEEDER_CHECKSUM_EN
    if (last) exp_q.push_back({1'b1, model_x});
`endif
    if (last) model_x = 8'h00;
  endtask

  // Presents word_q entries; called and returns at posedge+1.
  task automatic push_words(input int budget);
    int cyc = 0;
    bit fire;
    while (word_q.size() > 0) begin
      word_valid = 1'b1;
      {word_last, word_in} = word_q[0];
      fire = word_ready;
      step();
      cyc++;
      if (fire) void'(word_q.pop_front());
      if (cyc > budget) begin
        timeout_fail("push_words");
        word_q.delete();
      end
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
    word_in    = '0;
  endtask

  // Consumes exp_q; mode 0 = ready held high, mode 1 = ready pattern 1,0,0,1.
  task automatic drain(input int mode, input int budget, output int cycles);
    int cyc = 0;
    bit held = 0;
    logic [8:0] hv = '0;
    while (exp_q.size() > 0) begin
      byte_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (held) chk("hold_stable", 32'({byte_valid, byte_last, byte_out}), 32'({1'b1, hv}));
      held = 0;
      if (byte_valid) begin
        if (byte_ready) chk("byte", 32'({byte_last, byte_out}), 32'(exp_q.pop_front()));
        else begin
          held = 1;
          hv = {byte_last, byte_out};
        end
      end
      step();
      cyc++;
      if (cyc > budget) begin
        timeout_fail("drain");
        exp_q.delete();
      end
    end
    byte_ready = 1'b0;
    cycles = cyc;
  endtask

  initial begin
    int cyc;
    int n;
    int accepted;
    logic [32:0] words [6];
    logic        exp_wr [6];

    // Reset state
    #2;
    chk("rst_word_ready", 32'(word_ready), 32'd1);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_last",  32'(byte_last),  32'd0);
    chk("rst_byte_out",   32'(byte_out),   32'h00);
    chk("rst_busy",       32'(busy),       32'd0);
    #10 rst = 1'b0;
    step();

    // Single word: latency, consecutive bytes, last flag
    word_valid = 1'b1; word_last = 1'b1; word_in = 32'hA1B2C3D4;
    step();
    word_valid = 1'b0; word_last = 1'b0; word_in = '0;
    chk("lat_n0_valid", 32'(byte_valid), 32'd0);
    chk("lat_n0_busy",  32'(busy),       32'd1);
    step();
    chk("lat_n1_valid", 32'(byte_valid), 32'd0);
    step();
    chk("lat_n2_valid", 32'(byte_valid), 32'd1);
    chk("lat_n2_byte",  32'(byte_out),   32'hA1);
`ifdef FEEDER_CHECKSUM_EN
    exp_q = '{9'h0A1, 9'h0B2, 9'h0C3, 9'h0D4, 9'h104};
    drain(0, 20, cyc);
    chk("single_cycles", 32'(cyc), 32'd5);
`else
    exp_q = '{9'h0A1, 9'h0B2, 9'h0C3, 9'h1D4};
    drain(0, 20, cyc);
    chk("single_cycles", 32'(cyc), 32'd4);
`endif
    chk("single_busy_after",  32'(busy),       32'd0);
    chk("single_valid_after", 32'(byte_valid), 32'd0);

    // Backpressure with ready toggling
    word_q.push_back({1'b1, 32'hA1B2C3D4});
    push_words(10);
`ifdef FEEDER_CHECKSUM_EN
    exp_q = '{9'h0A1, 9'h0B2, 9'h0C3, 9'h0D4, 9'h104};
`else
    exp_q = '{9'h0A1, 9'h0B2, 9'h0C3, 9'h1D4};
`endif
    drain(1, 40, cyc);
    chk("bp_busy_after", 32'(busy), 32'd0);

    // FIFO fill with byte_ready low; includes push during LOAD pop
    exp_wr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      words[k] = {(k == 5), 8'(16*k), 8'(16*k+1), 8'(16*k+2), 8'(16*k+3)};
      add_exp(words[k][31:0], words[k][32]);
    end
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      bit fire;
      word_valid = 1'b1;
      {word_last, word_in} = words[accepted];
      fire = word_ready;
      step();
      if (fire) accepted++;
      chk("full_word_ready", 32'(word_ready), 32'(exp_wr[k]));
    end
    chk("full_accepted", 32'(accepted), 32'd5);
    chk("full_valid_held", 32'(byte_valid), 32'd1);
    chk("full_first_byte", 32'(byte_out), 32'h00);
    word_q.push_back(words[5]);
    fork
      push_words(40);
      drain(0, 200, cyc);
    join
    chk("full_busy_after", 32'(busy), 32'd0);

    // Pointer wrap: 10 words in one frame, streamed continuously
    for (int k = 0; k < 10; k++) begin
      word_q.push_back({(k == 9), 32'(k)});
      add_exp(32'(k), (k == 9));
    end
    fork
      push_words(100);
      drain(0, 200, cyc);
    join
`ifdef FEEDER_CHECKSUM_EN
    chk("wrap_cycles", 32'(cyc), 32'd53);
`else
    chk("wrap_cycles", 32'(cyc), 32'd52);
`endif
    chk("wrap_busy_after", 32'(busy), 32'd0);

    // Reset during the second byte of a two-word frame
    word_q.push_back({1'b0, 32'h11223344});
    word_q.push_back({1'b1, 32'h55667788});
    push_words(10);
    byte_ready = 1'b1;
    n = 0;
    while (!byte_valid && n < 10) begin
      step();
      n++;
    end
    chk("mid_first_byte", 32'(byte_out), 32'h11);
    step();
    chk("mid_second_byte", 32'(byte_out), 32'h22);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(byte_valid), 32'd0);
    chk("mid_rst_last",  32'(byte_last),  32'd0);
    chk("mid_rst_byte",  32'(byte_out),   32'h00);
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_ready", 32'(word_ready), 32'd1);
    byte_ready = 1'b0;
    #2 rst = 1'b0;
    step();
    word_q.push_back({1'b1, 32'h01020304});
    push_words(10);
`ifdef FEEDER_CHECKSUM_EN
    exp_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h104};
`else
    exp_q = '{9'h001, 9'h002, 9'h003, 9'h104};
`endif
    drain(0, 20, cyc);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
